select_toggle_ctrl: RTL and testbench

Upstream control stage for the 2:1 lab mux: generates the mux select line `s` from a raw push-button and a mode switch. It synchronizes and debounces the button, toggles `s` once per accepted press, and can optionally alternate `s` automatically at a fixed period. Output `s` drives the mux select directly; `x1`/`x2` routing is unaffected.

---
 rtl/select_toggle_ctrl_pkg.sv | 17 +
 rtl/btn_debounce.sv | 101 ++++++++++
 rtl/select_toggle_ctrl.sv | 72 +++++++
 tb/tb_select_toggle_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/select_toggle_ctrl_pkg.sv
// Shared definitions for the mux-select control stage: debounce FSM encodings
// and counter-width helper, used by the RTL and the bench monitors.
package select_toggle_ctrl_pkg;

  typedef logic [1:0] db_state_t;

  localparam db_state_t IDLE_LOW  = 2'd0;
  localparam db_state_t WAIT_HIGH = 2'd1;
  localparam db_state_t IDLE_HIGH = 2'd2;
  localparam db_state_t WAIT_LOW  = 2'd3;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debouncer: emits a registered debounced level
// and a same-edge press strobe when a rising level is accepted.
module btn_debounce
  import select_toggle_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_db,
  output logic press
);

  localparam int unsigned CW = cnt_bits(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync;
  logic          btn_s;
  db_state_t     state;
  db_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          db_nxt;

  assign btn_s = sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[0], btn};
    end
  end

  // press is taken from the next-state decision so the top toggles s on the
  // same edge that btn_db rises.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    db_nxt    = btn_db;
    press     = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (btn_s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!btn_s) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
          db_nxt    = 1'b1;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      IDLE_HIGH: begin
        if (!btn_s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (btn_s) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
          db_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE_LOW;
      cnt    <= '0;
      btn_db <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      btn_db <= db_nxt;
    end
  end

endmodule

// File: rtl/select_toggle_ctrl.sv
// Mux select generator: toggles s on each accepted button press and, in auto
// mode, every AUTO_PERIOD cycles.
module select_toggle_ctrl
  import select_toggle_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned AUTO_PERIOD     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic auto_en,
  output logic s,
  output logic s_changed,
  output logic btn_db
);

  localparam int unsigned AW = cnt_bits(AUTO_PERIOD);
  localparam logic [AW-1:0] ACNT_LAST = AW'(AUTO_PERIOD - 1);

  logic [1:0]    auto_sync;
  logic          auto_s;
  logic [AW-1:0] acnt;
  logic          press;
  logic          tick;
  logic          toggle;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .btn_db(btn_db),
    .press (press)
  );

  assign auto_s = auto_sync[1];
  assign tick   = auto_s && (acnt == ACNT_LAST);
  assign toggle = press | tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      auto_sync <= '0;
    end else begin
      auto_sync <= {auto_sync[0], auto_en};
    end
  end

  // A press restarts the auto period; a press coinciding with a tick is a
  // single toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acnt <= '0;
    end else if (!auto_s || toggle) begin
      acnt <= '0;
    end else begin
      acnt <= acnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s         <= 1'b0;
      s_changed <= 1'b0;
    end else begin
      s         <= s ^ toggle;
      s_changed <= toggle;
    end
  end

endmodule

// File: tb/tb_select_toggle_ctrl.sv
// Bench for select_toggle_ctrl: per-scenario stimulus tables and an expected
// output queue built from the documented toggle / debounce edge numbers.
module tb_select_toggle_ctrl;
  import select_toggle_ctrl_pkg::*;

  localparam int unsigned DC = 4;
  localparam int unsigned AP = 8;

  logic clk = 1'b0;
  logic reset;
  logic btn;
  logic auto_en;
  logic s;
  logic s_changed;
  logic btn_db;

  always #5 clk = ~clk;

  select_toggle_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .AUTO_PERIOD    (AP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .auto_en  (auto_en),
    .s        (s),
    .s_changed(s_changed),
    .btn_db   (btn_db)
  );

  typedef struct {
    int unsigned at;
    logic        btn;
    logic        auto_en;
  } stim_t;

  typedef struct {
    int unsigned at;
    logic        s;
    logic        chg;
    logic        db;
  } exp_t;

  stim_t       stim_q[$];
  exp_t        sb_q[$];
  int unsigned tog_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input int unsigned at,
                     input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", nm, at, act, exp);
    end
  endtask

  task automatic st(input int unsigned at, input logic b, input logic a);
    stim_t r;
    r.at = at;
    r.btn = b;
    r.auto_en = a;
    stim_q.push_back(r);
  endtask

  task automatic tg(input int unsigned at);
    tog_q.push_back(at);
  endtask

  // Expected outputs for edges 1..n from the toggle list and the btn_db
  // rise/fall edges (0 = none); s starts at s0.
  task automatic plan(input int unsigned n, input logic s0,
                      input int unsigned db_hi, input int unsigned db_lo);
    exp_t e;
    logic s_e;
    s_e = s0;
    for (int unsigned k = 1; k <= n; k++) begin
      e.chg = 1'b0;
      foreach (tog_q[i]) if (tog_q[i] == k) e.chg = 1'b1;
      if (e.chg) s_e = ~s_e;
      e.at = k;
      e.s  = s_e;
      e.db = (db_hi != 0) && (k >= db_hi) && ((db_lo == 0) || (k < db_lo));
      sb_q.push_back(e);
    end
    tog_q.delete();
  endtask

  task automatic run(input string tag, input int unsigned n);
    exp_t e;
    for (int unsigned k = 1; k <= n; k++) begin
      while (stim_q.size() > 0 && stim_q[0].at == k) begin
        btn     = stim_q[0].btn;
        auto_en = stim_q[0].auto_en;
        void'(stim_q.pop_front());
      end
      @(posedge clk);
      #1;
      while (sb_q.size() > 0 && sb_q[0].at == k) begin
        e = sb_q.pop_front();
        chk({tag, ".s"},         k, {3'b0, s},         {3'b0, e.s});
        chk({tag, ".s_changed"}, k, {3'b0, s_changed}, {3'b0, e.chg});
        chk({tag, ".btn_db"},    k, {3'b0, btn_db},    {3'b0, e.db});
      end
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s.leftover: got %0d pending expected 0", tag, sb_q.size());
      sb_q.delete();
    end
    stim_q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset   = 1'b1;
    btn     = 1'b0;
    auto_en = 1'b0;
    #1;
    chk({tag, ".s"},         0, {3'b0, s},             4'd0);
    chk({tag, ".s_changed"}, 0, {3'b0, s_changed},     4'd0);
    chk({tag, ".btn_db"},    0, {3'b0, btn_db},        4'd0);
    chk({tag, ".state"},     0, {2'b0, dut.u_db.state}, {2'b0, IDLE_LOW});
    chk({tag, ".cnt"},       0, {1'b0, dut.u_db.cnt},   4'd0);
    chk({tag, ".acnt"},      0, {1'b0, dut.acnt},       4'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    btn     = 1'b0;
    auto_en = 1'b0;
    do_reset("rst0");

    // Clean press held 20 cycles, then release
    st(1, 1'b1, 1'b0);
    st(21, 1'b0, 1'b0);
    tg(6);
    plan(30, 1'b0, 6, 26);
    run("press", 30);

    // Bounce: high 2, low 1, high 12
    do_reset("rst1");
    st(1, 1'b1, 1'b0);
    st(3, 1'b0, 1'b0);
    st(4, 1'b1, 1'b0);
    st(16, 1'b0, 1'b0);
    tg(9);
    plan(24, 1'b0, 9, 21);
    run("bounce", 24);

    // Glitch shorter than the debounce window
    do_reset("rst2");
    st(1, 1'b1, 1'b0);
    st(4, 1'b0, 1'b0);
    plan(12, 1'b0, 0, 0);
    run("glitch", 12);
    chk("glitch.state", 12, {2'b0, dut.u_db.state}, {2'b0, IDLE_LOW});

    // Auto mode, then drop auto_en
    do_reset("rst3");
    st(1, 1'b0, 1'b1);
    st(30, 1'b0, 1'b0);
    tg(10); tg(18); tg(26);
    plan(40, 1'b0, 0, 0);
    run("auto", 40);
    chk("auto.acnt", 40, {1'b0, dut.acnt}, 4'd0);

    // Press accepted on the same edge as an auto tick
    do_reset("rst4");
    st(1, 1'b0, 1'b1);
    st(13, 1'b1, 1'b1);
    st(30, 1'b0, 1'b1);
    tg(10); tg(18); tg(26); tg(34);
    plan(38, 1'b0, 18, 35);
    run("collide", 38);

    // Press mid-period restarts the auto period
    do_reset("rst5");
    st(1, 1'b0, 1'b1);
    st(9, 1'b1, 1'b1);
    st(27, 1'b0, 1'b1);
    tg(10); tg(14); tg(22); tg(30);
    plan(34, 1'b0, 14, 32);
    run("restart", 34);

    // Async reset right after a toggle, button still held
    do_reset("rst6");
    st(1, 1'b1, 1'b0);
    tg(6);
    plan(6, 1'b0, 6, 0);
    run("pre_async", 6);
    #2;
    reset = 1'b1;
    #1;
    chk("async.s",         6, {3'b0, s},         4'd0);
    chk("async.s_changed", 6, {3'b0, s_changed}, 4'd0);
    chk("async.btn_db",    6, {3'b0, btn_db},    4'd0);
    @(negedge clk);
    reset = 1'b0;
    tg(6);
    plan(10, 1'b0, 6, 0);
    run("post_async", 10);

    // Reset while in WAIT_HIGH with cnt=2
    do_reset("rst7");
    st(1, 1'b1, 1'b0);
    plan(4, 1'b0, 0, 0);
    run("middb", 4);
    chk("middb.state", 4, {2'b0, dut.u_db.state}, {2'b0, WAIT_HIGH});
    chk("middb.cnt",   4, {1'b0, dut.u_db.cnt},   4'd2);
    #2;
    reset = 1'b1;
    btn   = 1'b0;
    #1;
    chk("middb.rst_state", 4, {2'b0, dut.u_db.state}, {2'b0, IDLE_LOW});
    chk("middb.rst_cnt",   4, {1'b0, dut.u_db.cnt},   4'd0);
    @(negedge clk);
    reset = 1'b0;
    plan(10, 1'b0, 0, 0);
    run("after_middb", 10);
    chk("after_middb.state", 10, {2'b0, dut.u_db.state}, {2'b0, IDLE_LOW});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
